uart_tx_buffered: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO, and the next generation of the existing `uart_tx`. It accepts bytes or words on an AXI-Stream sink and buffers them in a FIFO. It serialises them on `txd` using a configurable frame: 5 to DATA_W data bits, parity of none/even/odd/mark/space, and 1, 1.5 or 2 stop bits. It also supports line-break generation. Bit timing comes from the shared oversampled baud tick, with a parametrised oversampling ratio.

---
 rtl/uart_tx_buffered.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
`timescale 1ns/1ps
// UART transmitter fed by an AXI-Stream transmit FIFO. It supports a configurable
// frame format and line breaks, and takes its bit timing from an oversampled baud tick.
module uart_tx_buffered #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OVS        = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BREAK_BITS = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_clk,
  input  logic [DATA_W-1:0]             s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [3:0]                    data_len,
  input  logic [1:0]                    stop_bits,
  input  logic                          parity_en,
  input  logic [1:0]                    parity_type,
  input  logic                          break_req,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned BRK_LEN  = BREAK_BITS * OVS;
  localparam int unsigned STOP_MAX = 2 * OVS;
  localparam int unsigned CNT_MAX  = (BRK_LEN > STOP_MAX) ? BRK_LEN : STOP_MAX;
  localparam int unsigned CW       = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK,
    MAB
  } state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [3:0]        bit_idx;
  logic [3:0]        len_q;
  logic [1:0]        stop_q;
  logic              par_en_q;
  logic              par_q;
  logic [DATA_W-1:0] shreg;

  logic [3:0]        len_in;
  logic [DATA_W-1:0] masked;
  logic              par_calc;
  logic [CW-1:0]     stop_last;
  logic              bit_last;
  logic              frame_end;
  logic              mab_end;
  logic              decide;

  assign full          = (level == (AW+1)'(FIFO_DEPTH));
  assign empty         = (level == '0);
  assign push          = s_axis_tvalid && !full;
  assign head          = mem[rd_ptr];
  assign s_axis_tready = !full;
  assign fifo_level    = level;
  assign busy          = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    if (data_len < 4'd5)               len_in = 4'd5;
    else if (data_len > 4'(DATA_W))    len_in = 4'(DATA_W);
    else                               len_in = data_len;
  end

  // Parity only covers the bits that will actually be sent.
  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      masked[i] = head[i] && (i < 32'(len_in));
    end
    case (parity_type)
      2'd0:    par_calc = ^masked;
      2'd1:    par_calc = ~^masked;
      2'd2:    par_calc = 1'b1;
      default: par_calc = 1'b0;
    endcase
  end

  always_comb begin
    case (stop_q)
      2'd0:    stop_last = CW'(OVS - 1);
      2'd1:    stop_last = CW'(3 * OVS / 2 - 1);
      default: stop_last = CW'(2 * OVS - 1);
    endcase
  end

  // The last tick of STOP or MAB makes the same choice as IDLE, so frames can
  // run back-to-back with no extra idle tick between them.
  assign bit_last  = (cnt == CW'(OVS - 1));
  assign frame_end = (state == STOP) && (cnt == stop_last);
  assign mab_end   = (state == MAB) && bit_last;
  assign decide    = (state == IDLE) || frame_end || mab_end;
  assign pop       = baud_clk && decide && !break_req && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      len_q    <= 4'd5;
      stop_q   <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      shreg    <= '0;
      txd      <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (baud_clk) begin
        if (decide) begin
          tx_done <= frame_end;
          cnt     <= '0;
          if (break_req) begin
            state <= BREAK;
            txd   <= 1'b0;
          end else if (!empty) begin
            state    <= START;
            txd      <= 1'b0;
            shreg    <= head;
            len_q    <= len_in;
            stop_q   <= stop_bits;
            par_en_q <= parity_en;
            par_q    <= par_calc;
          end else begin
            state <= IDLE;
            txd   <= 1'b1;
          end
        end else begin
          case (state)
            START: begin
              if (bit_last) begin
                state   <= DATA;
                cnt     <= '0;
                bit_idx <= '0;
                txd     <= shreg[0];
                shreg   <= shreg >> 1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            DATA: begin
              if (bit_last) begin
                cnt <= '0;
                if (bit_idx == len_q - 4'd1) begin
                  if (par_en_q) begin
                    state <= PARITY;
                    txd   <= par_q;
                  end else begin
                    state <= STOP;
                    txd   <= 1'b1;
                  end
                end else begin
                  bit_idx <= bit_idx + 4'd1;
                  txd     <= shreg[0];
                  shreg   <= shreg >> 1;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            PARITY: begin
              if (bit_last) begin
                state <= STOP;
                cnt   <= '0;
                txd   <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            STOP: cnt <= cnt + 1'b1;
            BREAK: begin
              // Saturate at the minimum length, then hold low until the request drops.
              if (cnt >= CW'(BRK_LEN - 1)) begin
                if (!break_req) begin
                  state <= MAB;
                  cnt   <= '0;
                  txd   <= 1'b1;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            MAB: cnt <= cnt + 1'b1;
            default: begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
`timescale 1ns/1ps
// Bench for uart_tx_buffered. It compares the tick-sampled txd stream against a
// frame-level reference, then runs FIFO, break and reset sequences.
module tb_uart_tx_buffered;

  localparam int DW = 9;
  localparam int OV = 8;
  localparam int FD = 16;
  localparam int BB = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          baud_clk = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [3:0]    data_len = 4'd8;
  logic [1:0]    stop_bits = 2'd0;
  logic          parity_en = 1'b0;
  logic [1:0]    parity_type = 2'd0;
  logic          break_req = 1'b0;
  logic          txd;
  logic          busy;
  logic          tx_done;
  logic [4:0]    fifo_level;

  uart_tx_buffered #(.DATA_W(DW), .OVS(OV), .FIFO_DEPTH(FD), .BREAK_BITS(BB)) dut (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .data_len(data_len), .stop_bits(stop_bits), .parity_en(parity_en),
    .parity_type(parity_type), .break_req(break_req),
    .txd(txd), .busy(busy), .tx_done(tx_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Baud ticks with irregular gaps between them; only the ticks should advance the timing.
  initial begin
    forever begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      baud_clk = 1'b1;
      @(negedge clk);
      baud_clk = 1'b0;
    end
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  bit   cap[$];
  bit   exp[$];
  int   done_idx[$];
  int   done_cnt = 0;
  int   first0 = -1;
  int   glitch_cnt = 0;
  int   full_seen = 0;
  int   ready_bad = 0;
  logic mon_tick, mon_rst, prev_txd;
  bit   prev_ok = 0;

  always @(posedge clk) begin
    mon_tick = baud_clk;
    mon_rst  = rst_n;
    #1;
    if (!mon_rst || !rst_n) begin
      prev_ok = 0;
    end else begin
      if (mon_tick) begin
        cap.push_back(txd);
        if (first0 < 0 && txd === 1'b0) first0 = cap.size() - 1;
      end else if (prev_ok && txd !== prev_txd) begin
        glitch_cnt++;
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_idx.push_back(cap.size() - 1);
      end
      if (fifo_level == 5'(FD)) begin
        full_seen++;
        if (s_axis_tready !== 1'b0) ready_bad++;
      end
      prev_txd = txd;
      prev_ok  = 1;
    end
  end

  task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic int eff_len(input int dl);
    return (dl < 5) ? 5 : ((dl > DW) ? DW : dl);
  endfunction

  function automatic int ref_parity(input logic [DW-1:0] w, input int dl, input int pt);
    int ones = 0;
    for (int i = 0; i < eff_len(dl); i++) ones += int'(w[i]);
    case (pt)
      0:       return ones % 2;
      1:       return 1 - (ones % 2);
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_ticks(input int sb);
    return (sb == 0) ? OV : ((sb == 1) ? (3 * OV) / 2 : 2 * OV);
  endfunction

  function automatic int ref_ticks(input int dl, input int pe, input int sb);
    return OV * (1 + eff_len(dl) + pe) + stop_ticks(sb);
  endfunction

  task automatic model_frame(input logic [DW-1:0] w, input int dl, input int sb,
                             input int pe, input int pt);
    repeat (OV) exp.push_back(1'b0);
    for (int i = 0; i < eff_len(dl); i++) repeat (OV) exp.push_back(w[i]);
    if (pe != 0) repeat (OV) exp.push_back(ref_parity(w, dl, pt) != 0);
    repeat (stop_ticks(sb)) exp.push_back(1'b1);
  endtask

  task automatic clear_cap();
    @(negedge clk);
    cap.delete();
    done_idx.delete();
    exp.delete();
    done_cnt  = 0;
    first0    = -1;
    full_seen = 0;
    ready_bad = 0;
  endtask

  task automatic set_cfg(input int dl, input int sb, input int pe, input int pt);
    @(negedge clk);
    data_len    = 4'(dl);
    stop_bits   = 2'(sb);
    parity_en   = (pe != 0);
    parity_type = 2'(pt);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    int i;
    @(negedge clk);
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    for (i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (s_axis_tready === 1'b1) break;
    end
    if (i == 5000) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: tready stayed low, expected high within 5000 cycles");
    end
  endtask

  task automatic end_push();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (baud_clk) k++;
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) break;
    end
    if (i == budget) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_idle_timeout: busy still 1 after %0d cycles, expected 0", nm, budget);
    end
    wait_ticks(4);
  endtask

  task automatic wait_after_start(input string nm, input int k, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (first0 >= 0 && cap.size() >= first0 + k) break;
    end
    if (i == budget) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_start_timeout: %0d ticks after start not reached, expected within %0d cycles",
               nm, k, budget);
    end
  endtask

  task automatic compare_stream(input string nm, output int s);
    int bad_at = -1;
    s = -1;
    for (int i = 0; i < cap.size(); i++) if (cap[i] == 1'b0) begin s = i; break; end
    n_cmp++;
    if (s < 0) begin
      s = cap.size();
      if (exp.size() != 0) begin
        n_bad++;
        $display("FAIL %s: no start bit in %0d ticks, expected a %0d-tick stream", nm, cap.size(), exp.size());
      end
      return;
    end
    if (cap.size() < s + exp.size()) begin
      n_bad++;
      $display("FAIL %s: stream length %0d ticks, expected at least %0d", nm, cap.size() - s, exp.size());
      return;
    end
    for (int k = 0; k < exp.size(); k++) if (cap[s+k] != exp[k]) begin bad_at = k; break; end
    if (bad_at >= 0) begin
      n_bad++;
      $display("FAIL %s: tick %0d txd=%0d, expected %0d", nm, bad_at, cap[s+bad_at], exp[bad_at]);
      return;
    end
    for (int j = s + exp.size(); j < cap.size(); j++) begin
      if (cap[j] != 1'b1) begin
        n_bad++;
        $display("FAIL %s: txd=0 at tick %0d past end, expected 1", nm, j - s);
        return;
      end
    end
  endtask

  typedef struct {
    logic [DW-1:0] word;
    int dl; int sb; int pe; int pt;
    int exp_ticks; int exp_par;
  } vec_t;

  vec_t vecs[8];
  vec_t rv;
  logic [DW-1:0] w1, w2;
  logic [DW-1:0] sw[20];
  int s;

  initial begin
    vecs[0] = '{9'h055, 8,  0, 0, 0, 80,  0};
    vecs[1] = '{9'h03F, 7,  1, 1, 0, 84,  0};
    vecs[2] = '{9'h0AA, 8,  2, 1, 1, 96,  1};
    vecs[3] = '{9'h1A5, 9,  0, 1, 2, 96,  1};
    vecs[4] = '{9'h0FF, 3,  0, 1, 0, 64,  1};
    vecs[5] = '{9'h0F0, 15, 3, 1, 1, 104, 1};
    vecs[6] = '{9'h1FF, 6,  1, 1, 3, 76,  0};
    vecs[7] = '{9'h080, 7,  0, 1, 0, 80,  0};

    repeat (3) @(negedge clk);
    check_eq("rst_txd", txd, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tx_done", tx_done, 0);
    check_eq("rst_fifo_level", fifo_level, 0);
    check_eq("rst_tready", s_axis_tready, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      set_cfg(vecs[v].dl, vecs[v].sb, vecs[v].pe, vecs[v].pt);
      clear_cap();
      model_frame(vecs[v].word, vecs[v].dl, vecs[v].sb, vecs[v].pe, vecs[v].pt);
      push_word(vecs[v].word);
      if (v == 0) begin
        #1;
        check_eq("push_busy_rise", busy, 1);
        check_eq("push_level_one", fifo_level, 1);
      end
      end_push();
      wait_idle($sformatf("vec%0d", v), 3000);
      compare_stream($sformatf("vec%0d_stream", v), s);
      check_eq($sformatf("vec%0d_len", v), (done_idx.size() > 0) ? done_idx[0] - s : -1, vecs[v].exp_ticks);
      if (vecs[v].pe != 0)
        check_eq($sformatf("vec%0d_parity", v),
                 (s + OV * (1 + eff_len(vecs[v].dl)) < cap.size()) ? cap[s + OV * (1 + eff_len(vecs[v].dl))] : 2,
                 vecs[v].exp_par);
      check_eq($sformatf("vec%0d_done", v), done_cnt, 1);
      check_eq($sformatf("vec%0d_busy_end", v), busy, 0);
    end

    for (int r = 0; r < 20; r++) begin
      rv.word = DW'($urandom);
      rv.dl = $urandom_range(0, 15);
      rv.sb = $urandom_range(0, 3);
      rv.pe = $urandom_range(0, 1);
      rv.pt = $urandom_range(0, 3);
      set_cfg(rv.dl, rv.sb, rv.pe, rv.pt);
      clear_cap();
      model_frame(rv.word, rv.dl, rv.sb, rv.pe, rv.pt);
      push_word(rv.word);
      end_push();
      wait_idle($sformatf("rnd%0d", r), 3000);
      compare_stream($sformatf("rnd%0d_stream", r), s);
      check_eq($sformatf("rnd%0d_len", r), (done_idx.size() > 0) ? done_idx[0] - s : -1,
               ref_ticks(rv.dl, rv.pe, rv.sb));
    end

    // Configuration changed mid-frame must only affect the following frame.
    set_cfg(8, 0, 0, 0);
    clear_cap();
    w1 = DW'($urandom);
    w2 = DW'($urandom);
    model_frame(w1, 8, 0, 0, 0);
    model_frame(w2, 6, 2, 1, 1);
    push_word(w1);
    push_word(w2);
    end_push();
    wait_after_start("cfg", 2, 2000);
    set_cfg(6, 2, 1, 1);
    wait_idle("cfg", 4000);
    compare_stream("cfg_latch_stream", s);
    check_eq("cfg_latch_done", done_cnt, 2);

    set_cfg(8, 0, 0, 0);
    clear_cap();
    for (int i = 0; i < 20; i++) begin
      sw[i] = DW'($urandom);
      model_frame(sw[i], 8, 0, 0, 0);
    end
    for (int i = 0; i < 20; i++) push_word(sw[i]);
    end_push();
    wait_idle("stress", 20000);
    compare_stream("stress_order", s);
    check_eq("stress_full_seen", full_seen > 0, 1);
    check_eq("stress_tready_when_full", ready_bad, 0);
    check_eq("stress_done", done_cnt, 20);
    check_eq("stress_level_end", fifo_level, 0);

    clear_cap();
    repeat (BB * OV) exp.push_back(1'b0);
    repeat (OV) exp.push_back(1'b1);
    model_frame(9'h0C3, 8, 0, 0, 0);
    @(negedge clk) break_req = 1'b1;
    wait_after_start("brk", 1, 2000);
    push_word(9'h0C3);
    end_push();
    wait_after_start("brk", 3, 2000);
    break_req = 1'b0;
    wait_idle("brk", 4000);
    compare_stream("break_stream", s);
    check_eq("break_done", done_cnt, 1);

    clear_cap();
    model_frame(9'h05A, 8, 0, 0, 0);
    push_word(9'h05A);
    end_push();
    wait_after_start("brk_mid", 10, 2000);
    break_req = 1'b1;
    wait_after_start("brk_mid", 40, 2000);
    @(negedge clk) break_req = 1'b0;
    wait_idle("brk_mid", 3000);
    compare_stream("break_ignored_in_frame", s);
    check_eq("break_ignored_done", done_cnt, 1);

    clear_cap();
    push_word(9'h011);
    push_word(9'h022);
    push_word(9'h033);
    end_push();
    wait_after_start("rst", OV + 3, 2000);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_eq("rst_mid_txd", txd, 1);
    check_eq("rst_mid_level", fifo_level, 0);
    check_eq("rst_mid_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    clear_cap();
    wait_ticks(200);
    compare_stream("rst_no_frame", s);
    check_eq("rst_no_done", done_cnt, 0);
    check_eq("txd_only_on_ticks", glitch_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at 900 us, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
